l1_cache: RTL and testbench
===========================

Name: l1_cache

Overview:
Direct-mapped, write-back, write-allocate L1 cache. It is the responder on the CPU-side memory interface (mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, mem_rdata, mem_resp) that the pipelined LC-3b datapath drives for instruction fetch and data access. One instance serves the I-side and one serves the D-side. On the physical side it issues whole-line (128-bit) reads and writebacks to the next memory level.

Parameters:
NUM_SETS, 8, number of lines; power of two, range 2..32; INDEX_W = log2(NUM_SETS).

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high; clears all state
mem_address  in  16  CPU byte address
mem_read  in  1  CPU read request
mem_write  in  1  CPU write request
mem_byte_enable  in  2  write mask; bit0 = low byte, bit1 = high byte
mem_wdata  in  16  CPU write data
mem_rdata  out  16  CPU read data, valid while mem_resp = 1
mem_resp  out  1  one-cycle completion pulse
pmem_address  out  16  line address, bits [3:0] = 0
pmem_read  out  1  line fill request
pmem_write  out  1  line writeback request
pmem_wdata  out  128  line data for writeback
pmem_rdata  in  128  line fill data
pmem_resp  in  1  physical completion pulse

Behaviour:
- Address split: offset = [3:0]; word select = [3:1]; index = [3+INDEX_W:4]; tag = [15:4+INDEX_W].
- Storage is flop-based per line: valid, dirty, tag, 128-bit data.
- Request = mem_read | mem_write. If both are high, the request is treated as a write.
- Hit = request & valid[index] & (tag[index] == tag).
- Hit path, state IDLE: mem_resp = 1 combinationally in the same cycle as the request, so hit latency is 0 wait cycles.
  - Read hit: mem_rdata = data[index][word*16 +: 16].
  - Write hit: at the clock edge, bytes are written under mem_byte_enable and dirty[index] is set. A byte_enable of 2'b00 completes with no data change but still sets dirty.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
  - IDLE, miss, victim valid & dirty -> WRITEBACK.
  - IDLE, miss, victim clean or invalid -> ALLOCATE.
  - IDLE, no request -> IDLE.
  - WRITEBACK: pmem_write = 1, pmem_address = {tag[index], index, 4'b0}, pmem_wdata = data[index]. On pmem_resp, clear dirty and go to ALLOCATE.
  - ALLOCATE: pmem_read = 1, pmem_address = {tag, index, 4'b0}. On pmem_resp, load the line, set valid, clear dirty, write the tag, and go to IDLE.
  - The retried request then hits in IDLE on the next cycle.
- mem_resp is 0 in WRITEBACK and ALLOCATE. pmem_read and pmem_write are never both 1. Both are held stable until pmem_resp.
- The index and tag used during a miss are captured at IDLE exit. Changes on mem_address during the miss do not affect the in-flight line.
- Request withdrawn mid-miss: the CPU may drop mem_read while a miss is pending (the I-side does this on a D-side stall). The current pmem transaction runs to completion, the line is installed, the FSM returns to IDLE, and no mem_resp is issued.
- After mem_resp, the CPU may deassert the request or present a new address in the next cycle. No stale resp is allowed.
- Reset (asynchronous, any state): state = IDLE; all valid and dirty bits = 0; mem_resp = pmem_read = pmem_write = 0 immediately; mem_rdata = 0; pmem_address = 0; pmem_wdata = 0. Tag and data contents are don't-care. An in-flight pmem transaction is abandoned.

Decomposition:
- Shared package additions: typedef lc3b_line (128 bits); constants LINE_OFFSET_W = 4 and WORD_SEL_W = 3.
- Existing lc3b_word and lc3b_mem_wmask are reused for the CPU port.
- One natural sub-module: l1_cache_ctrl, the FSM that generates pmem handshakes and load enables.
- The datapath (arrays, comparator, word and byte merge) stays in l1_cache.

Test Plan:
1. After reset, read 0x0042 -> ALLOCATE with pmem_address = 0x0040. Return pmem_rdata word1 = 0xBEEF; one cycle later mem_resp = 1 and mem_rdata = 0xBEEF, with no pmem_write.
2. Write 0x0043, byte_enable = 2'b10, wdata = 0x12AB on the resident line -> same-cycle mem_resp. A following read of 0x0042 returns 0x12EF.
3. The dirty line (index 4 with NUM_SETS = 8) is evicted by a read of 0x0842 -> pmem_write at 0x0040 with pmem_wdata word1 = 0x12EF, then pmem_read at 0x0840, then resp.
4. mem_read is dropped two cycles into ALLOCATE -> the fill completes, no mem_resp is issued, and a re-read of the same address hits with 0 wait cycles.
5. Reset is asserted during WRITEBACK -> pmem_write = 0 in the same cycle, and the next read of any address misses.
6. mem_read and mem_write are asserted together on a hit, with byte_enable = 2'b11 and wdata = 0x5A5A -> treated as a write; a subsequent read returns 0x5A5A.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// Shared types and constants for the L1 cache slice.
package l1_cache_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_mem_wmask;
  typedef logic [127:0] lc3b_line;

  localparam int LINE_OFFSET_W = 4;
  localparam int WORD_SEL_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } cache_state_e;

endpackage

// File: rtl/l1_cache_ctrl.sv
// Miss-handling FSM: sequences writeback/fill handshakes on the physical
// side and produces the load enables used by the cache datapath.
//
// Handshake: pmem_read / pmem_write are raised on entry to ALLOCATE /
// WRITEBACK and held unchanged until the cycle in which pmem_resp is
// sampled high; the transfer completes at that clock edge. They are never
// both high. The CPU side needs no handshake beyond the combinational
// hit/resp pulse generated in the datapath while idle.
module l1_cache_ctrl
  import l1_cache_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         request,
  input  logic         hit,
  input  logic         victim_dirty,
  input  logic         pmem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic         capture,
  output logic         load_line,
  output logic         clear_dirty,
  output logic         idle,
  output cache_state_e state_dbg
);

  cache_state_e state_q, state_d;

  assign state_dbg = state_q;

  // State register; reset abandons any in-flight physical transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake/enable decode.
  always_comb begin
    state_d     = state_q;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    capture     = 1'b0;
    load_line   = 1'b0;
    clear_dirty = 1'b0;
    idle        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idle = 1'b1;
        if (request && !hit) begin
          capture = 1'b1;
          state_d = victim_dirty ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          clear_dirty = 1'b1;
          state_d     = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_line = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with flop-based
// line storage. Hits complete combinationally while idle; misses are
// handled by l1_cache_ctrl using the index/tag captured at idle exit.
module l1_cache
  import l1_cache_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [1:0]    mem_byte_enable,
  input  logic [15:0]   mem_wdata,
  output logic [15:0]   mem_rdata,
  output logic          mem_resp,
  output logic [15:0]   pmem_address,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [127:0]  pmem_wdata,
  input  logic [127:0]  pmem_rdata,
  input  logic          pmem_resp
);

  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int TAG_W   = 16 - LINE_OFFSET_W - INDEX_W;

  logic [INDEX_W-1:0]    index;
  logic [TAG_W-1:0]      tag;
  logic [WORD_SEL_W-1:0] word_sel;
  logic                  unused_addr_bit;

  assign index           = mem_address[LINE_OFFSET_W +: INDEX_W];
  assign tag             = mem_address[LINE_OFFSET_W + INDEX_W +: TAG_W];
  assign word_sel        = mem_address[1 +: WORD_SEL_W];
  assign unused_addr_bit = mem_address[0];

  logic [NUM_SETS-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  lc3b_line            data_q [NUM_SETS];
  logic [INDEX_W-1:0]  miss_index_q;
  logic [TAG_W-1:0]    miss_tag_q;

  logic request, hit, victim_dirty, write_hit;
  logic capture, load_line, clear_dirty, idle;
  // FSM state is kept visible on the controller instance for bound checkers.
  cache_state_e fsm_state_unused;

  assign request      = mem_read | mem_write;
  assign hit          = request & valid_q[index] & (tag_q[index] == tag);
  assign victim_dirty = valid_q[index] & dirty_q[index];
  assign mem_resp     = idle & hit;
  assign write_hit    = mem_resp & mem_write;

  l1_cache_ctrl u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .request      (request),
    .hit          (hit),
    .victim_dirty (victim_dirty),
    .pmem_resp    (pmem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .capture      (capture),
    .load_line    (load_line),
    .clear_dirty  (clear_dirty),
    .idle         (idle),
    .state_dbg    (fsm_state_unused)
  );

  lc3b_word rd_word, merged_word;
  lc3b_line merged_line;

  // Word select for reads and byte merge of CPU write data into the line.
  always_comb begin
    rd_word     = data_q[index][{word_sel, 4'b0000} +: 16];
    merged_word = rd_word;
    if (mem_byte_enable[0]) merged_word[7:0]  = mem_wdata[7:0];
    if (mem_byte_enable[1]) merged_word[15:8] = mem_wdata[15:8];
    merged_line = data_q[index];
    merged_line[{word_sel, 4'b0000} +: 16] = merged_word;
  end

  // Read data is only driven while a read (not write) is completing.
  assign mem_rdata = (mem_resp && !mem_write) ? rd_word : 16'h0000;

  // Physical-side address/data; zero whenever no transaction is active.
  always_comb begin
    pmem_address = 16'h0000;
    pmem_wdata   = '0;
    if (pmem_write) begin
      pmem_address = {tag_q[miss_index_q], miss_index_q, {LINE_OFFSET_W{1'b0}}};
      pmem_wdata   = data_q[miss_index_q];
    end else if (pmem_read) begin
      pmem_address = {miss_tag_q, miss_index_q, {LINE_OFFSET_W{1'b0}}};
    end
  end

  // Line status bits and the miss index/tag latched at idle exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      dirty_q      <= '0;
      miss_index_q <= '0;
      miss_tag_q   <= '0;
    end else begin
      if (capture) begin
        miss_index_q <= index;
        miss_tag_q   <= tag;
      end
      if (write_hit)   dirty_q[index]        <= 1'b1;
      if (clear_dirty) dirty_q[miss_index_q] <= 1'b0;
      if (load_line) begin
        valid_q[miss_index_q] <= 1'b1;
        dirty_q[miss_index_q] <= 1'b0;
      end
    end
  end

  // Tag and data arrays; contents are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (load_line) begin
      data_q[miss_index_q] <= pmem_rdata;
      tag_q[miss_index_q]  <= miss_tag_q;
    end
    if (write_hit) data_q[index] <= merged_line;
  end

endmodule

// File: tb/tb_l1_cache.sv
// Bench for l1_cache: CPU-side driver task, behavioural next-level memory,
// reference memory image, and a scoreboard of expected read data.
module tb_l1_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata, mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  l1_cache #(.NUM_SETS(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory models ----------------
  logic [127:0] bk_line  [logic [11:0]];  // next-level memory contents
  logic [127:0] ref_line [logic [11:0]];  // what the CPU should observe
  logic [15:0]  exp_q[$];
  logic [15:0]  wb_addr_q[$];
  logic [127:0] wb_data_q[$];
  logic [15:0]  rd_addr_q[$];
  int           kind_q[$];
  int           resp_lat  = 0;
  bit           hold_resp = 1'b0;

  function automatic logic [127:0] init_line(input logic [11:0] la);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[w*16 +: 16] = {la, 4'(w)};
    return l;
  endfunction

  function automatic logic [127:0] get_bk(input logic [11:0] la);
    if (bk_line.exists(la)) return bk_line[la];
    return init_line(la);
  endfunction

  function automatic logic [127:0] get_ref(input logic [11:0] la);
    if (ref_line.exists(la)) return ref_line[la];
    return get_bk(la);
  endfunction

  function automatic void clear_logs();
    wb_addr_q.delete();
    wb_data_q.delete();
    rd_addr_q.delete();
    kind_q.delete();
  endfunction

  // ---------------- next-level memory responder ----------------
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset && !hold_resp && (pmem_read || pmem_write)) begin
        logic [15:0] a;
        bit          is_wr;
        int          lat;
        a     = pmem_address;
        is_wr = pmem_write;
        check("pmem_excl", {pmem_read, pmem_write}, is_wr ? 2'b01 : 2'b10);
        check("pmem_align", a[3:0], 4'h0);
        lat = (resp_lat != 0) ? resp_lat : $urandom_range(1, 3);
        repeat (lat - 1) @(negedge clk);
        if (!reset && (is_wr ? pmem_write : pmem_read)) begin
          check("pmem_addr_stable", pmem_address, a);
          if (is_wr) begin
            wb_addr_q.push_back(a);
            wb_data_q.push_back(pmem_wdata);
            kind_q.push_back(0);
            bk_line[a[15:4]] = pmem_wdata;
          end else begin
            rd_addr_q.push_back(a);
            kind_q.push_back(1);
            pmem_rdata = get_bk(a[15:4]);
          end
          pmem_resp = 1'b1;
          @(negedge clk);
          pmem_resp = 1'b0;
        end
      end
    end
  end

  // ---------------- CPU driver ----------------
  // Called at posedge+1; returns at posedge+1 with the request dropped.
  task automatic cpu_op(input logic [15:0] addr, input bit rd, input bit wr,
                        input logic [1:0] be, input logic [15:0] wd, output int waits);
    logic [11:0]  la;
    logic [127:0] line;
    logic [15:0]  w, exp;
    bit           got;
    la = addr[15:4];
    mem_address = addr; mem_read = rd; mem_write = wr;
    mem_byte_enable = be; mem_wdata = wd;
    if (rd && !wr) begin
      line = get_ref(la);
      exp_q.push_back(line[{addr[3:1], 4'b0000} +: 16]);
    end
    waits = 0;
    got   = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mem_resp) begin got = 1'b1; break; end
      waits++;
    end
    check("resp_timeout", got, 1'b1);
    if (rd && !wr) begin
      exp = exp_q.pop_front();
      if (got) check("rdata", mem_rdata, exp);
    end
    if (wr && got) begin
      line = get_ref(la);
      w = line[{addr[3:1], 4'b0000} +: 16];
      if (be[0]) w[7:0]  = wd[7:0];
      if (be[1]) w[15:8] = wd[15:8];
      line[{addr[3:1], 4'b0000} +: 16] = w;
      ref_line[la] = line;
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int           waits, nresp;
    bit           seen;
    logic [127:0] l;
    logic [15:0]  a;
    int           op;

    reset = 1'b1;
    mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 2'b00; mem_wdata = '0;
    l = init_line(12'h004);
    l[31:16] = 16'hBEEF;
    bk_line[12'h004] = l;
    repeat (3) @(posedge clk); #1;
    check("rst_mem_resp", mem_resp, 1'b0);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_address", pmem_address, 16'h0000);
    check("rst_mem_rdata", mem_rdata, 16'h0000);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: cold read miss, clean allocate
    clear_logs();
    cpu_op(16'h0042, 1, 0, 2'b00, 16'h0, waits);
    check("t1_miss_waits", waits > 0, 1'b1);
    check("t1_fill_cnt", rd_addr_q.size(), 1);
    check("t1_fill_addr", rd_addr_q.size() > 0 ? rd_addr_q[0] : 16'hFFFF, 16'h0040);
    check("t1_no_wb", wb_addr_q.size(), 0);

    // 2: write hit high byte, then read back
    cpu_op(16'h0043, 0, 1, 2'b10, 16'h12AB, waits);
    check("t2_wr_hit_waits", waits, 0);
    @(negedge clk);
    check("t2_no_stale_resp", mem_resp, 1'b0);
    @(posedge clk); #1;
    cpu_op(16'h0042, 1, 0, 2'b00, 16'h0, waits);
    check("t2_rd_hit_waits", waits, 0);

    // 3: dirty eviction by conflicting tag
    clear_logs();
    cpu_op(16'h0842, 1, 0, 2'b00, 16'h0, waits);
    check("t3_wb_cnt", wb_addr_q.size(), 1);
    check("t3_wb_addr", wb_addr_q.size() > 0 ? wb_addr_q[0] : 16'hFFFF, 16'h0040);
    l = (wb_data_q.size() > 0) ? wb_data_q[0] : '0;
    check("t3_wb_word1", l[31:16], 16'h12EF);
    check("t3_fill_addr", rd_addr_q.size() > 0 ? rd_addr_q[0] : 16'hFFFF, 16'h0840);
    check("t3_order", kind_q.size() == 2 ? {kind_q[0][0], kind_q[1][0]} : 2'b11, 2'b01);
    cpu_op(16'h0042, 1, 0, 2'b00, 16'h0, waits);
    check("t3_reread_miss", waits > 0, 1'b1);

    // 4: request withdrawn two cycles into ALLOCATE
    clear_logs();
    resp_lat = 6;
    nresp = 0;
    mem_address = 16'h0150; mem_read = 1'b1;
    repeat (3) begin
      @(negedge clk); nresp += int'(mem_resp);
      @(posedge clk);
    end
    #1;
    mem_read = 1'b0; mem_address = 16'h3FF0;
    repeat (15) begin
      @(negedge clk); nresp += int'(mem_resp);
    end
    resp_lat = 0;
    check("t4_no_resp", nresp, 0);
    check("t4_fill_addr", rd_addr_q.size() == 1 ? rd_addr_q[0] : 16'hFFFF, 16'h0150);
    @(posedge clk); #1;
    cpu_op(16'h0150, 1, 0, 2'b00, 16'h0, waits);
    check("t4_rehit_waits", waits, 0);

    // 5: reset during WRITEBACK
    cpu_op(16'h0044, 0, 1, 2'b11, 16'h7777, waits);
    check("t5_wr_hit_waits", waits, 0);
    hold_resp = 1'b1;
    mem_address = 16'h0842; mem_read = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pmem_write) begin seen = 1'b1; break; end
    end
    check("t5_wb_seen", seen, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_pmem_write", pmem_write, 1'b0);
    check("t5_rst_pmem_read", pmem_read, 1'b0);
    check("t5_rst_mem_resp", mem_resp, 1'b0);
    check("t5_rst_pmem_address", pmem_address, 16'h0000);
    check("t5_rst_pmem_wdata", pmem_wdata, 128'h0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    reset = 1'b0;
    hold_resp = 1'b0;
    ref_line.delete();
    cpu_op(16'h0150, 1, 0, 2'b00, 16'h0, waits);
    check("t5_post_rst_miss_a", waits > 0, 1'b1);
    cpu_op(16'h0042, 1, 0, 2'b00, 16'h0, waits);
    check("t5_post_rst_miss_b", waits > 0, 1'b1);

    // 6: read and write together is a write
    cpu_op(16'h0042, 1, 1, 2'b11, 16'h5A5A, waits);
    check("t6_rw_hit_waits", waits, 0);
    cpu_op(16'h0042, 1, 0, 2'b00, 16'h0, waits);
    check("t6_rd_hit_waits", waits, 0);

    // random mix over a few conflicting tags
    for (int i = 0; i < 60; i++) begin
      a  = 16'($urandom_range(0, 16'hFFFF)) & 16'hC0FE;
      op = $urandom_range(0, 2);
      cpu_op(a, op != 1, op != 0, 2'($urandom_range(0, 3)),
             16'($urandom_range(0, 16'hFFFF)), waits);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
